conv_encoder_top: RTL and testbench
===================================

Name: conv_encoder_top

Overview:
Rate-1/2, K=3 convolutional encoder (generators g0=7, g1=5 octal). It is the transmit-side counterpart of the Viterbi decoder system.
- Accepts 8-bit payload bytes over a valid/ready handshake.
- Encodes them bit-serially, MSB first.
- Emits one 16-bit coded word per byte, in the symbol format the decoder's input FIFO consumes.
- Trellis state persists across bytes; an explicit flush, or an optional idle-timeout flush, returns the trellis to state 00.

Parameters:
IDLE_LIMIT, 20, idle cycles before auto flush (used only with ENC_AUTO_FLUSH_EN).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
valid_i  input  1  payload byte valid
data_i  input  8  payload byte; bit 7 is encoded first
ready_o  output  1  block can accept a byte or flush this cycle
flush_i  input  1  request termination word (encode 0x00)
valid_o  output  1  coded word valid
data_o  output  16  coded word; symbol k (k=0 first) in data_o[15-2k:14-2k] = {c0,c1}
tail_o  output  1  qualifies data_o as a flush/termination word
ready_i  input  1  downstream accepts word when valid_o && ready_i

Behaviour:
- Reset (async, any state, including mid-shift):
  - FSM to IDLE; trellis state {s1,s0}=00; bit counter 0; idle counter 0.
  - valid_o=0, data_o=0, tail_o=0; ready_o=1 after reset deasserts.
- Encoder equations, input bit u:
  - c0=u^s0^s1; c1=u^s1.
  - Next state: s1<=s0, s0<=u.
- FSM states:
  - IDLE: ready_o=1 (combinational from state register only).
    - valid_i=1: latch data_i into shift register, tail flag=0, go to SHIFT.
    - else flush_i=1: latch 0x00, tail flag=1, go to SHIFT.
    - valid_i and flush_i together: byte wins; flush_i is ignored and must be re-requested.
  - SHIFT: ready_o=0.
    - One bit per cycle, MSB first.
    - Symbol written to data_o slot indexed by the 3-bit counter.
    - After the 8th bit, set valid_o=1 and tail_o=tail flag, go to OUT.
  - OUT: ready_o=0; data_o/tail_o held stable while valid_o && !ready_i.
    - On ready_i=1: valid_o<=0, go to IDLE.
- Latency and throughput:
  - Handshake at edge N gives valid_o=1 after edge N+8.
  - With ready_i tied high, minimum byte period is 10 cycles.
- Flush from any trellis state produces end state 00, because 8 zero bits clear the K-1=2 register. A flush in state 00 still emits 0x0000 with tail_o=1.
- data_o register is updated only in SHIFT. Its value outside valid_o is don't-care for checking but deterministic.

Optional Feature:
ENC_AUTO_FLUSH_EN:
- Defined:
  - Idle counter increments each IDLE cycle with valid_i=0, flush_i=0 and trellis state != 00.
  - Counter clears on any handshake, on a flush, or when state==00.
  - When the count reaches IDLE_LIMIT, an internal flush starts exactly as flush_i would (tail_o=1 on the resulting word).
  - Same-cycle valid_i still takes priority.
- Undefined: no idle counter; termination happens only via flush_i; IDLE_LIMIT unused.

Test Plan:
1. Reset, ready_i=1, send 0x80 -> valid_o 8 cycles after handshake, data_o=0xEC00, tail_o=0; next ready_o=1.
2. From reset send 0xFF -> 0xDAAA; then send 0xFF again (state 11) -> 0xAAAA.
3. From reset send 0x01 -> 0x0003; pulse flush_i -> 0xB000 with tail_o=1; then flush_i again -> 0x0000, tail_o=1.
4. Backpressure: send 0x80 with ready_i=0 for 5 cycles -> valid_o and 0xEC00 held stable, ready_o=0 throughout; ready_i=1 releases; next byte accepted the following cycle.
5. valid_i and flush_i asserted together in IDLE -> byte encoded, tail_o=0, no flush word produced. Async reset asserted mid-SHIFT -> valid_o=0, state 00; re-sending 0x80 gives 0xEC00.
6. (ENC_AUTO_FLUSH_EN) Send 0x01, then stay idle -> after IDLE_LIMIT idle cycles, word 0xB000 with tail_o=1, and no further auto flush. Without the macro -> no output.

Source files
------------

// File: rtl/conv_encoder_top_if.sv
// conv_encoder_top_if: payload-in / coded-word-out handshake bundle of the
// rate-1/2 convolutional encoder.
//   valid_i, data_i[7:0], flush_i, ready_o : payload byte / flush request side
//   valid_o, data_o[15:0], tail_o, ready_i : coded word side
// Modports:
//   slave  - encoder view (consumes payload, produces coded words)
//   master - environment view (produces payload, consumes coded words)
interface conv_encoder_top_if;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        flush_i;
    logic        ready_o;
    logic        valid_o;
    logic [15:0] data_o;
    logic        tail_o;
    logic        ready_i;

    modport slave (
        input  valid_i,
        input  data_i,
        input  flush_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
        output tail_o
    );

    modport master (
        output valid_i,
        output data_i,
        output flush_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  tail_o
    );
endinterface

// File: rtl/conv_encoder_top.sv
// conv_encoder_top: rate-1/2, K=3 convolutional encoder (g0=7, g1=5 octal).
// A payload byte is taken on a valid/ready handshake, encoded MSB first at one
// bit per clock, and presented as one 16-bit coded word whose symbol k (k=0
// first) sits in data_o[15-2k:14-2k] = {c0,c1}. The trellis state persists
// across bytes; a flush encodes 0x00, returning the trellis to state 00, and
// marks the word with tail_o.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - conv_encoder_top_if.slave (valid_i/data_i/flush_i/ready_o on
//            the payload side, valid_o/data_o/tail_o/ready_i on the output)
//
// Parameters:
//   IDLE_LIMIT - idle cycles (non-zero trellis state, no request) before an
//                automatic flush; only meaningful with ENC_AUTO_FLUSH_EN.
//
// Build option:
//   ENC_AUTO_FLUSH_EN - when defined, an idle counter starts a flush on its
//                       own after IDLE_LIMIT idle cycles in a non-zero state.
module conv_encoder_top #(
    parameter int unsigned IDLE_LIMIT = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_encoder_top_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    state_t      state_r,     state_s;
    logic [7:0]  shreg_r,     shreg_s;
    logic [2:0]  cnt_r,       cnt_s;
    logic [1:0]  trellis_r,   trellis_s;   // {s1,s0}
    logic        tail_flag_r, tail_flag_s;
    logic        valid_r,     valid_s;
    logic [15:0] data_r,      data_s;
    logic        tail_r,      tail_s;
    logic [1:0]  sym_s;
    logic        auto_flush_s;

    // One trellis step: returns {c0,c1} for input bit u and state {s1,s0}.
    function automatic logic [1:0] conv_sym(input logic u, input logic [1:0] st);
        conv_sym = {u ^ st[0] ^ st[1], u ^ st[1]};
    endfunction

`ifdef ENC_AUTO_FLUSH_EN
    localparam int unsigned IdleW = (IDLE_LIMIT < 32'd2) ? 32'd1 : $clog2(IDLE_LIMIT + 32'd1);

    logic [IdleW-1:0] idle_cnt_r, idle_cnt_s;

    // The count can only reach the limit in a non-zero state, since state 00
    // clears it; the state term guards a degenerate IDLE_LIMIT of 0.
    assign auto_flush_s = (state_r == ST_IDLE) && (trellis_r != 2'b00) &&
                          (idle_cnt_r == IdleW'(IDLE_LIMIT));

    // Idle counter next value: counts quiet IDLE cycles while the trellis is dirty.
    always_comb begin
        idle_cnt_s = idle_cnt_r;
        if (state_r != ST_IDLE) begin
            idle_cnt_s = '0;
        end else if (bus.valid_i || bus.flush_i || auto_flush_s || (trellis_r == 2'b00)) begin
            idle_cnt_s = '0;
        end else if (idle_cnt_r != IdleW'(IDLE_LIMIT)) begin
            idle_cnt_s = idle_cnt_r + {{(IdleW-1){1'b0}}, 1'b1};
        end else begin
            idle_cnt_s = idle_cnt_r;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_s;
        end
    end
`else
    // No automatic termination in this build; the limit term is constant false.
    assign auto_flush_s = 1'b0 && (IDLE_LIMIT == 32'd0);
`endif

    assign sym_s = conv_sym(shreg_r[7], trellis_r);

    // Next-state and datapath next values; every register defaults to hold.
    always_comb begin
        state_s     = state_r;
        shreg_s     = shreg_r;
        cnt_s       = cnt_r;
        trellis_s   = trellis_r;
        tail_flag_s = tail_flag_r;
        valid_s     = valid_r;
        data_s      = data_r;
        tail_s      = tail_r;
        case (state_r)
            ST_IDLE: begin
                // A byte wins over a same-cycle flush; the flush is dropped.
                if (bus.valid_i) begin
                    shreg_s     = bus.data_i;
                    tail_flag_s = 1'b0;
                    cnt_s       = 3'd0;
                    state_s     = ST_SHIFT;
                end else if (bus.flush_i || auto_flush_s) begin
                    shreg_s     = 8'h00;
                    tail_flag_s = 1'b1;
                    cnt_s       = 3'd0;
                    state_s     = ST_SHIFT;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                data_s[4'd15 - {cnt_r, 1'b0} -: 2] = sym_s;
                trellis_s = {trellis_r[0], shreg_r[7]};
                shreg_s   = {shreg_r[6:0], 1'b0};
                cnt_s     = cnt_r + 3'd1;
                if (cnt_r == 3'd7) begin
                    valid_s = 1'b1;
                    tail_s  = tail_flag_r;
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_OUT: begin
                if (bus.ready_i) begin
                    valid_s = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r     <= 8'h00;
            cnt_r       <= 3'd0;
            trellis_r   <= 2'b00;
            tail_flag_r <= 1'b0;
            valid_r     <= 1'b0;
            data_r      <= 16'h0000;
            tail_r      <= 1'b0;
        end else begin
            shreg_r     <= shreg_s;
            cnt_r       <= cnt_s;
            trellis_r   <= trellis_s;
            tail_flag_r <= tail_flag_s;
            valid_r     <= valid_s;
            data_r      <= data_s;
            tail_r      <= tail_s;
        end
    end

    assign bus.ready_o = (state_r == ST_IDLE);
    assign bus.valid_o = valid_r;
    assign bus.data_o  = data_r;
    assign bus.tail_o  = tail_r;

endmodule

// File: tb/tb_conv_encoder_top.sv
// tb_conv_encoder_top: scoreboard bench for conv_encoder_top. The driver
// pushes the expected coded word (from a generator-polynomial reference model)
// at each handshake; a negedge monitor compares whatever the encoder presents.
module tb_conv_encoder_top;

    localparam int unsigned LIMIT = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_encoder_top_if bus_if ();

    conv_encoder_top #(.IDLE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [15:0] d;
        logic        t;
        int          hs;   // handshake cycle, -1 when unknown
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [1:0] m_st = 2'b00;  // model trellis state {older, newer}
    bit         in_word = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: taps g0=111 and g1=101 over the window {u, d1, d2}.
    function automatic logic [15:0] ref_word(input logic [7:0] b, input logic [1:0] st,
                                             output logic [1:0] st_o);
        logic [2:0]  w;
        logic [15:0] word;
        logic        d1, d2;
        d1   = st[0];
        d2   = st[1];
        word = 16'h0000;
        for (int i = 7; i >= 0; i--) begin
            w    = {b[i], d1, d2};
            word = {word[13:0], ^(w & 3'b111), ^(w & 3'b101)};
            d2   = d1;
            d1   = b[i];
        end
        st_o = {d2, d1};
        return word;
    endfunction

    task automatic expect_word(input logic [7:0] b, input logic t, input int hs);
        exp_t       e;
        logic [1:0] ns;
        e.d  = ref_word(b, m_st, ns);
        e.t  = t;
        e.hs = hs;
        m_st = ns;
        q.push_back(e);
    endtask

    task automatic wait_ready(input bit rnd);
        int n = 0;
        while (!bus_if.ready_o && n < 100) begin
            if (rnd) bus_if.ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, bus_if.ready_o}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic v, input logic f, input bit rnd);
        wait_ready(rnd);
        bus_if.valid_i = v;
        bus_if.data_i  = b;
        bus_if.flush_i = f;
        @(posedge clk); #1;
        bus_if.valid_i = 1'b0;
        bus_if.flush_i = 1'b0;
        if (v) expect_word(b, 1'b0, cyc);
        else if (f) expect_word(8'h00, 1'b1, cyc);
    endtask

    task automatic drain();
        int n = 0;
        bus_if.ready_i = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compares every presented word against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus_if.valid_o) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got data=%h tail=%b, expected no word", bus_if.data_o, bus_if.tail_o);
            end else begin
                if (!in_word) begin
                    in_word = 1'b1;
                    if (q[0].hs >= 0) chk("latency", cyc - q[0].hs, 32'd8);
                end
                chk("data", {16'd0, bus_if.data_o}, {16'd0, q[0].d});
                chk("tail", {31'd0, bus_if.tail_o}, {31'd0, q[0].t});
                chk("ready_o_busy", {31'd0, bus_if.ready_o}, 32'd0);
                if (bus_if.ready_i) begin
                    void'(q.pop_front());
                    in_word = 1'b0;
                end
            end
        end
    end

    task automatic start_reset();
        rst_n = 1'b0;
        q.delete();
        in_word = 1'b0;
        m_st = 2'b00;
    endtask

    task automatic end_reset();
        idle(2);
        rst_n = 1'b1;
        chk("ready_after_reset", {31'd0, bus_if.ready_o}, 32'd1);
    endtask

    initial begin
        bus_if.valid_i = 1'b0;
        bus_if.data_i  = 8'h00;
        bus_if.flush_i = 1'b0;
        bus_if.ready_i = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_o", {31'd0, bus_if.valid_o}, 32'd0);
        chk("rst_data_o", {16'd0, bus_if.data_o}, 32'd0);
        chk("rst_tail_o", {31'd0, bus_if.tail_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_reset", {31'd0, bus_if.ready_o}, 32'd1);

        // Single 0x80 from state 00, then ready again
        send(8'h80, 1'b1, 1'b0, 1'b0);
        drain();
        chk("ready_after_word", {31'd0, bus_if.ready_o}, 32'd1);

        // 0xFF twice: second one starts in state 11
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b0);
        drain();

        // 0x01, flush from state 01, flush from state 00
        start_reset();
        end_reset();
        send(8'h01, 1'b1, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b1, 1'b0);
        drain();

        // Backpressure: word held while ready_i low, next byte right after release
        bus_if.ready_i = 1'b0;
        send(8'h80, 1'b1, 1'b0, 1'b0);
        idle(13);
        chk("bp_ready_o", {31'd0, bus_if.ready_o}, 32'd0);
        chk("bp_valid_o", {31'd0, bus_if.valid_o}, 32'd1);
        bus_if.ready_i = 1'b1;
        idle(1);
        chk("ready_after_release", {31'd0, bus_if.ready_o}, 32'd1);
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        drain();

        // Byte and flush together: only the byte word appears
        send(8'h5A, 1'b1, 1'b1, 1'b0);
        drain();
        idle(15);

        // Asynchronous reset in the middle of a shift
        send(8'hC3, 1'b1, 1'b0, 1'b0);
        idle(3);
        start_reset();
        #1;
        chk("midrst_valid_o", {31'd0, bus_if.valid_o}, 32'd0);
        chk("midrst_data_o", {16'd0, bus_if.data_o}, 32'd0);
        chk("midrst_tail_o", {31'd0, bus_if.tail_o}, 32'd0);
        end_reset();
        send(8'h80, 1'b1, 1'b0, 1'b0);
        drain();

        // Idle with a dirty trellis
        send(8'h01, 1'b1, 1'b0, 1'b0);
        drain();
`ifdef ENC_AUTO_FLUSH_EN
        expect_word(8'h00, 1'b1, -1);
        idle(LIMIT + 20);
        drain();
`endif
        idle(LIMIT + 40);
        chk("idle_no_word", q.size(), 32'd0);

        // Randomized bytes, flushes and output backpressure
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 2) send(8'h00, 1'b0, 1'b1, 1'b1);
            else send(8'($urandom), 1'b1, ($urandom_range(0, 4) == 0), 1'b1);
        end
        drain();
        idle(5);
        chk("final_queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
